ni_inject: RTL and testbench

NI_INJECT -- requirements
Module: ni_inject

---
 rtl/ni_inject.sv | 164 ++++++++++++++++
 tb/tb_ni_inject.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_inject.sv
// Network-interface packet injector: builds head/body/tail flits and gates them on per-VC credits (NI_SRCID_EN puts source coords in the head).
// Latency: request accepted in cycle T puts the head on the registered outputs in T+2; each later flit follows its issue decision by one cycle.
// Backpressure: req_ready only while idle; a VC with zero credit stalls head/body issue and holds pld_ready low.
module ni_inject #(
    parameter int DATAW    = 32,
    parameter int ARRAYW   = 3,
    parameter int VCHW     = 2,
    parameter int BUFDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [ARRAYW-1:0] my_xpos,
    input  logic [ARRAYW-1:0] my_ypos,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ARRAYW-1:0] req_dst_x,
    input  logic [ARRAYW-1:0] req_dst_y,
    input  logic [VCHW-1:0]   req_vch,
    input  logic [3:0]        req_len,
    input  logic              pld_valid,
    input  logic [DATAW-1:0]  pld_data,
    output logic              pld_ready,
    output logic              o_valid,
    output logic [DATAW-1:0]  o_data,
    output logic [1:0]        o_type,
    output logic [VCHW-1:0]   o_vch,
    input  logic              i_credit,
    input  logic [VCHW-1:0]   i_credit_vch
);
    localparam int NVC = 1 << VCHW;
    localparam int CW  = $clog2(BUFDEPTH + 1);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    typedef struct packed {
        logic [ARRAYW-1:0] src_y;
        logic [ARRAYW-1:0] src_x;
        logic [ARRAYW-1:0] dst_y;
        logic [ARRAYW-1:0] dst_x;
    } hdr_t;

    state_t            state, state_nxt;
    logic [ARRAYW-1:0] dst_x, dst_y, src_x, src_y;
    logic [VCHW-1:0]   vch;
    logic [3:0]        len, cnt;
    logic [CW-1:0]     credit [NVC];
    logic [NVC-1:0]    take, give;
    logic              accept, has_credit, issue;
    logic [DATAW-1:0]  flit_dat;
    logic [1:0]        flit_type;
    hdr_t              hdr;

`ifdef NI_SRCID_EN
    assign src_x = my_xpos;
    assign src_y = my_ypos;
`else
    assign src_x = '0;
    assign src_y = '0;
    logic unused_pos;
    assign unused_pos = ^{my_xpos, my_ypos};
`endif

    assign hdr        = '{src_y: src_y, src_x: src_x, dst_y: dst_y, dst_x: dst_x};
    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign has_credit = (credit[vch] != '0);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pld_ready = 1'b0;
        flit_dat  = '0;
        flit_type = T_BODY;
        case (state)
            IDLE: if (req_valid) state_nxt = HEAD;
            HEAD: begin
                if (has_credit) begin
                    issue    = 1'b1;
                    flit_dat = DATAW'(hdr);
                    if (len == 4'd0) begin
                        flit_type = T_HT;
                        state_nxt = IDLE;
                    end else begin
                        flit_type = T_HEAD;
                        state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                pld_ready = has_credit;
                if (has_credit && pld_valid) begin
                    issue    = 1'b1;
                    flit_dat = pld_data;
                    // cnt holds body flits already sent, so len-1 marks the last one
                    if (cnt == len - 4'd1) begin
                        flit_type = T_TAIL;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            take[v] = issue && (vch == VCHW'(v));
            give[v] = i_credit && (i_credit_vch == VCHW'(v));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= IDLE;
            dst_x <= '0;
            dst_y <= '0;
            vch   <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dst_x <= req_dst_x;
                dst_y <= req_dst_y;
                vch   <= req_vch;
                len   <= req_len;
                cnt   <= '0;
            end else if (issue && state == BODY) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // A return and an issue on the same VC cancel; returns saturate at BUFDEPTH
    always_ff @(posedge clk) begin
        for (int v = 0; v < NVC; v++) begin
            if (!rst_)
                credit[v] <= CW'(BUFDEPTH);
            else if (give[v] && !take[v] && credit[v] != CW'(BUFDEPTH))
                credit[v] <= credit[v] + CW'(1);
            else if (take[v] && !give[v])
                credit[v] <= credit[v] - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_type  <= '0;
            o_vch   <= '0;
        end else begin
            o_valid <= issue;
            o_data  <= flit_dat;
            o_type  <= flit_type;
            o_vch   <= issue ? vch : '0;
        end
    end
endmodule

// File: tb/tb_ni_inject.sv
// Randomised + directed bench for ni_inject against a packet-level reference model.
module tb_ni_inject;
    logic        clk = 1'b0;
    logic        rst_;
    logic [2:0]  my_xpos, my_ypos;
    logic        req_valid, req_ready;
    logic [2:0]  req_dst_x, req_dst_y;
    logic [1:0]  req_vch;
    logic [3:0]  req_len;
    logic        pld_valid, pld_ready;
    logic [31:0] pld_data;
    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_type, o_vch;
    logic        i_credit;
    logic [1:0]  i_credit_vch;

`ifdef NI_SRCID_EN
    localparam bit SRC_EN = 1'b1;
`else
    localparam bit SRC_EN = 1'b0;
`endif

    ni_inject dut (
        .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_vch(req_vch), .req_len(req_len),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
        .o_valid(o_valid), .o_data(o_data), .o_type(o_type), .o_vch(o_vch),
        .i_credit(i_credit), .i_credit_vch(i_credit_vch)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_flit = 0;
    int n_tail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] head_word(int dx, int dy);
        int w;
        w = dx + dy * 8;
        if (SRC_EN) w += int'(my_xpos) * 64 + int'(my_ypos) * 512;
        return 32'(w);
    endfunction

    // Reference model: one packet in flight, tracked as "head still owed" plus body flits left.
    bit          mdl_ok = 0;
    bit          busy, head_pend;
    int          left, pv, pdx, pdy, plen;
    int          cred [4];
    bit          ev;
    logic [31:0] ed;
    logic [1:0]  et;
    int          evc;

    always @(negedge clk) begin
        int tk;
        if (mdl_ok) begin
            chk("o_valid", 32'(o_valid), 32'(ev));
            if (ev) begin
                chk("o_data", o_data, ed);
                chk("o_type", 32'(o_type), 32'(et));
                chk("o_vch", 32'(o_vch), 32'(evc));
            end
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("pld_ready", 32'(pld_ready), 32'(busy && !head_pend && cred[pv] > 0));
        end
        if (o_valid) begin
            n_flit++;
            if (o_type[1]) n_tail++;
        end
        if (!rst_) begin
            busy = 0; head_pend = 0; left = 0; pv = 0;
            foreach (cred[v]) cred[v] = 4;
            ev = 0;
            mdl_ok = 1;
        end else if (mdl_ok) begin
            tk = -1;
            ev = 0;
            if (busy && head_pend && cred[pv] > 0) begin
                ev = 1; ed = head_word(pdx, pdy); et = (plen == 0) ? 2'b11 : 2'b01;
                head_pend = 0; busy = (plen != 0); tk = pv; evc = pv;
            end else if (busy && !head_pend && cred[pv] > 0 && pld_valid) begin
                left--;
                ev = 1; ed = pld_data; et = (left == 0) ? 2'b10 : 2'b00;
                busy = (left != 0); tk = pv; evc = pv;
            end else if (!busy && req_valid) begin
                busy = 1; head_pend = 1;
                pv = int'(req_vch); pdx = int'(req_dst_x); pdy = int'(req_dst_y);
                plen = int'(req_len); left = plen;
            end
            if (i_credit && tk != int'(i_credit_vch))
                cred[i_credit_vch] = (cred[i_credit_vch] < 4) ? cred[i_credit_vch] + 1 : 4;
            if (tk >= 0 && !(i_credit && int'(i_credit_vch) == tk))
                cred[tk]--;
        end
    end

    task automatic send(input int dx, input int dy, input int vc, input int ln);
        req_valid = 1; req_dst_x = 3'(dx); req_dst_y = 3'(dy);
        req_vch = 2'(vc); req_len = 4'(ln);
        tick();
        req_valid = 0;
    endtask

    task automatic give_credits(input int vc, input int n);
        i_credit = 1; i_credit_vch = 2'(vc);
        repeat (n) tick();
        i_credit = 0;
    endtask

    initial begin
        int f0, t0;
        logic [5:0] src_bits;
        src_bits = SRC_EN ? 6'b001_001 : 6'b000_000;
        rst_ = 0; my_xpos = 3'd1; my_ypos = 3'd1;
        req_valid = 0; req_dst_x = 0; req_dst_y = 0; req_vch = 0; req_len = 0;
        pld_valid = 0; pld_data = 0; i_credit = 0; i_credit_vch = 0;
        repeat (2) tick();
        rst_ = 1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_type", 32'(o_type), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // single head+tail, T+2 latency
        send(3, 2, 1, 0);
        chk("ht_early", 32'(o_valid), 32'd0);
        tick();
        chk("ht_valid", 32'(o_valid), 32'd1);
        chk("ht_type", 32'(o_type), 32'd3);
        chk("ht_vch", 32'(o_vch), 32'd1);
        chk("ht_dst", 32'(o_data[5:0]), 32'(6'b010_011));
        chk("ht_src", 32'(o_data[11:6]), 32'(src_bits));
        chk("ht_rdy", 32'(req_ready), 32'd1);

        // len=3 stream with payload always valid
        pld_valid = 1; pld_data = 32'hA;
        send(0, 0, 3, 3);
        tick();
        chk("s_head", 32'(o_type), 32'd1);
        tick(); pld_data = 32'hB;
        chk("s_b0", o_data, 32'hA);
        chk("s_b0t", 32'(o_type), 32'd0);
        tick(); pld_data = 32'hC;
        chk("s_b1", o_data, 32'hB);
        tick();
        chk("s_tail", o_data, 32'hC);
        chk("s_tailt", 32'(o_type), 32'd2);
        pld_valid = 0;
        tick();

        // credit exhaustion on vch0
        pld_valid = 1; pld_data = 32'h55;
        f0 = n_flit;
        send(0, 1, 0, 7);
        repeat (14) tick();
        chk("cr_stall", 32'(n_flit - f0), 32'd4);
        give_credits(0, 1);
        repeat (8) tick();
        chk("cr_one", 32'(n_flit - f0), 32'd5);
        give_credits(0, 6);
        repeat (4) tick();
        pld_valid = 0;

        // saturation then same-cycle issue/return on vch2
        give_credits(2, 2);
        send(2, 2, 2, 0);
        give_credits(2, 1);
        tick();
        pld_valid = 1;
        f0 = n_flit;
        send(1, 0, 2, 7);
        repeat (16) tick();
        chk("cr_sat", 32'(n_flit - f0), 32'd4);
        give_credits(2, 6);
        repeat (4) tick();

        // reset mid-body abandons the packet
        send(4, 4, 1, 5);
        repeat (4) tick();
        rst_ = 0;
        tick();
        rst_ = 1;
        chk("mr_rdy", 32'(req_ready), 32'd1);
        chk("mr_vld", 32'(o_valid), 32'd0);
        f0 = n_flit; t0 = n_tail;
        repeat (10) tick();
        chk("mr_noflit", 32'(n_flit - f0), 32'd0);
        chk("mr_notail", 32'(n_tail - t0), 32'd0);
        f0 = n_flit;
        send(5, 5, 1, 7);
        repeat (14) tick();
        chk("mr_cred4", 32'(n_flit - f0), 32'd4);
        give_credits(1, 6);
        repeat (4) tick();
        pld_valid = 0;

        // local loopback
        send(1, 1, 0, 0);
        tick();
        chk("lb_type", 32'(o_type), 32'd3);
        chk("lb_dst", 32'(o_data[5:0]), 32'(6'b001_001));
        tick();

        repeat (3000) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_dst_x = 3'($urandom); req_dst_y = 3'($urandom);
            req_vch = 2'($urandom); req_len = 4'($urandom);
            pld_valid = ($urandom_range(0, 3) != 0);
            pld_data = $urandom;
            i_credit = ($urandom_range(0, 9) < 4);
            i_credit_vch = 2'($urandom);
            rst_ = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_ = 1; req_valid = 0; pld_valid = 0; i_credit = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
